round_robin_stream_merger_2: RTL

Merges two valid/ready packet streams into one output stream. Arbitration between the inputs is round-robin, and a grant is held for a whole packet, from first beat to the beat with last=1. It sits directly downstream of the two request sources and directly upstream of a single shared consumer. It has one registered output stage, so the path from input to output takes one cycle.

---
 rtl/stream_merger_pkg.sv | 13 +
 rtl/rr_pick_2.sv | 23 ++
 rtl/round_robin_stream_merger_2.sv | 113 +++++++++++
 3 files changed

// File: rtl/stream_merger_pkg.sv
// Shared types and constants for the two-input round-robin stream merger.
package stream_merger_pkg;

    // Arbitration state: idle, or holding a grant mid-packet on one input.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } merge_state_t;

    localparam int NUM_INPUTS = 2;

endpackage : stream_merger_pkg

// File: rtl/rr_pick_2.sv
// Combinational two-way round-robin picker.
// A lone request always wins; the pointer only breaks a tie.
module rr_pick_2
    import stream_merger_pkg::*;
(
    input  logic [NUM_INPUTS-1:0] requests,
    input  logic                  pointer,
    output logic [NUM_INPUTS-1:0] pick
);

    // One-hot pick from the request pair, pointer decides on contention
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick = '0;
        case (requests)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = pointer ? 2'b10 : 2'b01;
            default: pick = '0;
        endcase
    end

endmodule : rr_pick_2

// File: rtl/round_robin_stream_merger_2.sv
// Merges two valid/ready packet streams into one registered output stream.
// Grants are round-robin and held from a packet's first beat to its last.
module round_robin_stream_merger_2
    import stream_merger_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    merge_state_t              state_q, state_d;
    logic                      ptr_q, ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic [WIDTH-1:0]          out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;
    logic                      out_src_q, out_src_d;

    logic                      can_load;
    logic [NUM_INPUTS-1:0]     pick;
    logic [NUM_INPUTS-1:0]     sel;
    logic                      acc0, acc1;

    rr_pick_2 u_pick (
        .requests ({in1_valid, in0_valid}),
        .pointer  (ptr_q),
        .pick     (pick)
    );

    // The output register can take a new beat when empty or being drained
    assign can_load = !out_valid_q || out_ready;

    // Selected input: the picker's choice when idle, the locked input otherwise
    always_comb begin
        sel = '0;
        case (state_q)
            IDLE:    sel = pick;
            LOCK0:   sel = 2'b01;
            LOCK1:   sel = 2'b10;
            default: sel = '0;
        endcase
    end

    assign in0_ready = can_load && sel[0];
    assign in1_ready = can_load && sel[1];
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;

    // Next state, pointer and output register contents from the accepted beat
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (can_load) begin
            out_valid_d = acc0 || acc1;
        end
        if (acc0) begin
            out_data_d = in0_data;
            out_last_d = in0_last;
            out_src_d  = 1'b0;
            ptr_d      = 1'b1;
            state_d    = in0_last ? IDLE : LOCK0;
        end else if (acc1) begin
            out_data_d = in1_data;
            out_last_d = in1_last;
            out_src_d  = 1'b1;
            ptr_d      = 1'b0;
            state_d    = in1_last ? IDLE : LOCK1;
        end
    end

    // State, pointer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule : round_robin_stream_merger_2
